half_duplex_fifo_bridge: RTL
============================

# half_duplex_fifo_bridge

Byte-stream front end for the half-duplex ISO7816 UART. It buffers outgoing bytes in a transmit FIFO and launches them into the UART one character at a time, with a programmable guard time between characters. It never starts a transmission while a reception is in progress. It also drains received characters and their frame-error status into a receive FIFO, acknowledging the UART flags automatically, so the host sees two simple FIFO ports instead of the UART's flag/ack handshake.

## Interface
- FIFO_DEPTH_LOG2, 2: log2 of the depth of each FIFO (depth 4).
- GUARD_WIDTH, 16: width of guardCycles.

- clk  in  1  single clock; the UART is clocked by the same clk.
- nReset  in  1  reset, synchronous, active-low.
- hostTxData  in  8  byte to transmit.
- hostTxWrite  in  1  push hostTxData; ignored when hostTxFull=1.
- hostTxFull  out  1  tx FIFO full.
- hostRxData  out  8  head of rx FIFO (first-word fall-through).
- hostRxFrameError  out  1  frame-error bit stored with the head byte.
- hostRxRead  in  1  pop rx head; ignored when hostRxEmpty=1.
- hostRxEmpty  out  1  rx FIFO empty.
- guardCycles  in  GUARD_WIDTH  idle clk cycles inserted after txRun falls, before the next launch.
- clearErrors  in  1  clears the sticky error flags.
- rxDropped  out  1  sticky: a byte arrived while the rx FIFO was full.
- uartOverrun  out  1  sticky: overrunErrorFlag was seen high.
- txBusy  out  1  tx state machine is not in TX_IDLE, or the tx FIFO is not empty.
- txData  out  8  to UART; equals the tx FIFO head.
- startTx  out  1  to UART.
- ackFlags  out  1  to UART; one-cycle pulse.
- txFull, txRun, rxRun, rxStartBit, endOfRx, dataOutReadyFlag, frameErrorFlag, overrunErrorFlag  in  1 each  from UART.
- rxData  in  8  from UART.

## Operation
- Both FIFOs are circular buffers with (FIFO_DEPTH_LOG2+1)-bit read and write pointers, so full and empty are unambiguous at wrap-around.
  - Tx FIFO entries are 8 bits.
  - Rx FIFO entries are 9 bits: {frameError, data}.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (host pop plus internal push) or empty (push only).

- Tx state machine:
  - TX_IDLE → TX_LOAD when the tx FIFO is not empty and rxStartBit=0 and rxRun=0.
  - TX_LOAD: startTx=1. When txFull=1, pop the tx FIFO and go to TX_WAIT. If rxStartBit or rxRun rises while in TX_LOAD, hold TX_LOAD; the UART gates the load, and the byte is not popped.
  - TX_WAIT: startTx=0. When txRun=0 and txFull=0, go to TX_GUARD with guard counter = guardCycles. If guardCycles=0, go directly to TX_IDLE.
  - TX_GUARD: decrement the counter each cycle; at 1 go to TX_IDLE. The state lasts exactly guardCycles cycles.

- Rx state machine:
  - RX_IDLE: when dataOutReadyFlag=1, push {frameErrorFlag, rxData}, pulse ackFlags on the next cycle, and go to RX_ACK.
  - If the rx FIFO is full (after accounting for a same-cycle host pop), drop the byte, set rxDropped, and still ack.
  - RX_ACK: ackFlags=1 for this one cycle, then RX_WAIT.
  - RX_WAIT: one cycle that lets the UART flags clear, then RX_IDLE. This state prevents a double push.
  - A frame error with no data-ready (bad stop bit) is also acknowledged from RX_IDLE. The byte is pushed with frameError=1.
  - overrunErrorFlag=1 in any cycle sets uartOverrun.

- clearErrors clears both sticky flags. A set condition in the same cycle as clearErrors wins.

- Reset mid-operation clears both FIFOs, returns both machines to their idle states, and drops startTx immediately. A UART character already in flight is abandoned.

## Timing
- Reset values: startTx=0, ackFlags=0, txData=0, hostTxFull=0, hostRxEmpty=1, hostRxData=0, hostRxFrameError=0, rxDropped=0, uartOverrun=0, txBusy=0.
- All outputs are registered or derived from registered state/pointers only. There are no combinational paths from inputs to outputs.
- hostTxWrite at edge N into an empty FIFO with an idle line: TX_LOAD and startTx=1 from edge N+1.
- Rx push at edge N, where dataOutReadyFlag was high before N: hostRxEmpty=0 and the data is valid after edge N. ackFlags is high between edges N and N+1. The next push is possible no earlier than edge N+3.
- The launch rule guarantees that startTx is never asserted while rxRun or rxStartBit is high on entry to TX_LOAD.

## Test plan
- Write 0x3B then 0xA5 with guardCycles=10 → two UART characters in order. The gap from txRun falling to the second startTx rising is exactly 11 clk cycles (10 guard cycles plus the TX_IDLE→TX_LOAD cycle). txBusy falls after the second character completes.
- Write 5 bytes with FIFO_DEPTH_LOG2=2 while the UART is stalled (txFull held 0) → hostTxFull=1 after the 4th write; the 5th is ignored. After the stall is released, only 4 characters are sent.
- Drive 6 received characters 0x10..0x15 with no host reads → the first 4 are stored; rxDropped=1 after the 5th. Each character gets exactly one ackFlags pulse. Reads return 0x10..0x13 with hostRxFrameError=0.
- Received character with frameErrorFlag=1, data 0x55 → the FIFO head is 0x55 with hostRxFrameError=1 and exactly one ack. A clearErrors pulse coinciding with an overrunErrorFlag pulse leaves uartOverrun=1.
- Host writes a byte while rxStartBit=1 → startTx stays 0 until rxRun and rxStartBit are both low, then the launch occurs. Assert nReset during TX_GUARD → all outputs at reset values on the next cycle, and both FIFOs are empty.

Source files
------------

// File: rtl/half_duplex_fifo_bridge_if.sv
// Signal bundle between the FIFO bridge and its surroundings (host FIFO ports plus the ISO7816 UART).
// The slave modport is the bridge's view; master is the host/UART side.
interface half_duplex_fifo_bridge_if #(
  parameter int GUARD_WIDTH = 16
);
  // Host tx port: hostTxWrite is a push strobe, accepted only while hostTxFull=0.
  // Host rx port: first-word fall-through; hostRxRead pops the head, accepted only while hostRxEmpty=0.
  logic [7:0]             hostTxData;
  logic                   hostTxWrite;
  logic                   hostTxFull;
  logic [7:0]             hostRxData;
  logic                   hostRxFrameError;
  logic                   hostRxRead;
  logic                   hostRxEmpty;
  logic [GUARD_WIDTH-1:0] guardCycles;
  logic                   clearErrors;
  logic                   rxDropped;
  logic                   uartOverrun;
  logic                   txBusy;

  // UART side
  logic [7:0]             txData;
  logic                   startTx;
  logic                   ackFlags;
  logic                   txFull;
  logic                   txRun;
  logic                   rxRun;
  logic                   rxStartBit;
  logic                   endOfRx;
  logic                   dataOutReadyFlag;
  logic                   frameErrorFlag;
  logic                   overrunErrorFlag;
  logic [7:0]             rxData;

  // State machine observation
  logic [1:0]             txStateDbg;
  logic [1:0]             rxStateDbg;

  modport slave (
    input  hostTxData, hostTxWrite, hostRxRead, guardCycles, clearErrors,
    input  txFull, txRun, rxRun, rxStartBit, endOfRx,
    input  dataOutReadyFlag, frameErrorFlag, overrunErrorFlag, rxData,
    output hostTxFull, hostRxData, hostRxFrameError, hostRxEmpty,
    output rxDropped, uartOverrun, txBusy,
    output txData, startTx, ackFlags,
    output txStateDbg, rxStateDbg
  );

  modport master (
    output hostTxData, hostTxWrite, hostRxRead, guardCycles, clearErrors,
    output txFull, txRun, rxRun, rxStartBit, endOfRx,
    output dataOutReadyFlag, frameErrorFlag, overrunErrorFlag, rxData,
    input  hostTxFull, hostRxData, hostRxFrameError, hostRxEmpty,
    input  rxDropped, uartOverrun, txBusy,
    input  txData, startTx, ackFlags,
    input  txStateDbg, rxStateDbg
  );
endinterface

// File: rtl/half_duplex_fifo_bridge.sv
// Tx/rx FIFO front end for the half-duplex ISO7816 UART: launches buffered bytes with a guard
// time, never while a reception is active, and drains received bytes with automatic flag acks.
module half_duplex_fifo_bridge #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int GUARD_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       nReset,
  half_duplex_fifo_bridge_if.slave   bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT, TX_GUARD} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rxState_e;

  // ---------------- tx FIFO ----------------
  logic [7:0]    txMem [DEPTH];
  logic [PW-1:0] txWrPtr, txRdPtr;
  logic          txEmpty, txFifoFull, txPush, txPop;

  assign txEmpty    = (txWrPtr == txRdPtr);
  assign txFifoFull = (txWrPtr[PW-1] != txRdPtr[PW-1]) &&
                      (txWrPtr[PW-2:0] == txRdPtr[PW-2:0]);
  assign txPush     = bus.hostTxWrite && !txFifoFull;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) txMem[i] <= '0;
    end else begin
      if (txPush) begin
        txMem[txWrPtr[PW-2:0]] <= bus.hostTxData;
        txWrPtr <= txWrPtr + PW'(1);
      end
      if (txPop) txRdPtr <= txRdPtr + PW'(1);
    end
  end

  // ---------------- tx state machine ----------------
  txState_e               txState, txStateNext;
  logic [GUARD_WIDTH-1:0] guardCnt, guardCntNext;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      txState  <= TX_IDLE;
      guardCnt <= '0;
    end else begin
      txState  <= txStateNext;
      guardCnt <= guardCntNext;
    end
  end

  always_comb begin
    txStateNext  = txState;
    guardCntNext = guardCnt;
    txPop        = 1'b0;
    case (txState)
      TX_IDLE: begin
        if (!txEmpty && !bus.rxStartBit && !bus.rxRun) txStateNext = TX_LOAD;
      end
      TX_LOAD: begin
        // The UART refuses the load while a reception starts, so the byte stays queued.
        if (bus.txFull) begin
          txPop       = 1'b1;
          txStateNext = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!bus.txRun && !bus.txFull) begin
          if (bus.guardCycles == '0) begin
            txStateNext = TX_IDLE;
          end else begin
            txStateNext  = TX_GUARD;
            guardCntNext = bus.guardCycles;
          end
        end
      end
      TX_GUARD: begin
        if (guardCnt == GUARD_WIDTH'(1)) txStateNext = TX_IDLE;
        else                             guardCntNext = guardCnt - GUARD_WIDTH'(1);
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  assign bus.startTx    = (txState == TX_LOAD);
  assign bus.txData     = txMem[txRdPtr[PW-2:0]];
  assign bus.hostTxFull = txFifoFull;
  assign bus.txBusy     = (txState != TX_IDLE) || !txEmpty;
  assign bus.txStateDbg = txState;

  // ---------------- rx FIFO ----------------
  logic [8:0]    rxMem [DEPTH];
  logic [PW-1:0] rxWrPtr, rxRdPtr;
  logic          rxEmpty, rxFifoFull, rxPush, rxPop, rxEvent, rxRoom, rxDrop;

  assign rxEmpty    = (rxWrPtr == rxRdPtr);
  assign rxFifoFull = (rxWrPtr[PW-1] != rxRdPtr[PW-1]) &&
                      (rxWrPtr[PW-2:0] == rxRdPtr[PW-2:0]);
  assign rxPop      = bus.hostRxRead && !rxEmpty;
  // A host pop in the same cycle frees the slot the new byte needs.
  assign rxRoom     = !rxFifoFull || rxPop;
  assign rxPush     = rxEvent && rxRoom;
  assign rxDrop     = rxEvent && !rxRoom;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) rxMem[i] <= '0;
    end else begin
      if (rxPush) begin
        rxMem[rxWrPtr[PW-2:0]] <= {bus.frameErrorFlag, bus.rxData};
        rxWrPtr <= rxWrPtr + PW'(1);
      end
      if (rxPop) rxRdPtr <= rxRdPtr + PW'(1);
    end
  end

  // ---------------- rx state machine ----------------
  rxState_e rxState, rxStateNext;

  always_ff @(posedge clk) begin
    if (!nReset) rxState <= RX_IDLE;
    else         rxState <= rxStateNext;
  end

  always_comb begin
    rxStateNext = rxState;
    rxEvent     = 1'b0;
    case (rxState)
      RX_IDLE: begin
        // A bad stop bit raises frameErrorFlag alone; it is still stored and acknowledged.
        if (bus.dataOutReadyFlag || bus.frameErrorFlag) begin
          rxEvent     = 1'b1;
          rxStateNext = RX_ACK;
        end
      end
      RX_ACK:  rxStateNext = RX_WAIT;
      RX_WAIT: rxStateNext = RX_IDLE;
      default: rxStateNext = RX_IDLE;
    endcase
  end

  assign bus.ackFlags         = (rxState == RX_ACK);
  assign bus.hostRxData       = rxMem[rxRdPtr[PW-2:0]][7:0];
  assign bus.hostRxFrameError = rxMem[rxRdPtr[PW-2:0]][8];
  assign bus.hostRxEmpty      = rxEmpty;
  assign bus.rxStateDbg       = rxState;

  // ---------------- sticky error flags (set beats clear) ----------------
  logic rxDroppedQ, uartOverrunQ;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rxDroppedQ   <= 1'b0;
      uartOverrunQ <= 1'b0;
    end else begin
      if (rxDrop)                rxDroppedQ <= 1'b1;
      else if (bus.clearErrors)  rxDroppedQ <= 1'b0;
      if (bus.overrunErrorFlag)  uartOverrunQ <= 1'b1;
      else if (bus.clearErrors)  uartOverrunQ <= 1'b0;
    end
  end

  assign bus.rxDropped   = rxDroppedQ;
  assign bus.uartOverrun = uartOverrunQ;

  logic unusedInputs;
  assign unusedInputs = bus.endOfRx;
endmodule
